// File: rtl/uart16550_tx_fifo_ctrl_if.sv
// UART 16550 TX holding path: THR write side and transmitter pop side.
// master = register file / transmitter, slave = TX FIFO controller.
interface uart16550_tx_fifo_ctrl_if;
  logic       wr;
  logic [7:0] wd;
  logic       pop;
  logic [7:0] d;

  modport master (
    output wr,
    output wd,
    output pop,
    input  d
  );

  modport slave (
    input  wr,
    input  wd,
    input  pop,
    output d
  );
endinterface

// File: rtl/uart16550_tx_fifo_ctrl.sv
// UART 16550 transmit holding controller: FIFO / 16450 holding reg, THRE/TEMT, THRE irq.
// Optional macro UART16550_TX_LEVEL_EN adds the level_o fill-level port.
module uart16550_tx_fifo_ctrl #(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic fifo_en_i,
  input  logic fifo_rst_i,
  uart16550_tx_fifo_ctrl_if.slave bus,
  input  logic sr_empty_i,
  output logic thre_o,
  output logic temt_o,
  input  logic ier_ethrei_i,
  input  logic iir_rd_i,
  output logic thre_irq_o,
  output logic overflow_o
`ifdef UART16550_TX_LEVEL_EN
  ,
  output logic [AW:0] level_o
`endif
);

  localparam logic [AW:0] CAP_FIFO = (AW+1)'(DEPTH);
  localparam logic [AW:0] CAP_HOLD = (AW+1)'(1);
  localparam logic [AW:0] ONE      = (AW+1)'(1);
  localparam logic [AW-1:0] PONE   = AW'(1);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, wr_ptr_n;
  logic [AW-1:0] rd_ptr, rd_ptr_n;
  logic [AW:0]   count, count_n;
  logic [AW:0]   cap;
  logic          thre_q;
  logic          pend, pend_n;
  logic          ovf_q, ovf_n;
  logic          en_q;
  logic          ethrei_q;
  logic          clr;
  logic          full, empty;
  logic          wr_ok, pop_ok;
  logic          set_pend;

  assign cap   = fifo_en_i ? CAP_FIFO : CAP_HOLD;
  assign full  = (count >= cap);
  assign empty = (count == '0);
  assign clr   = fifo_rst_i | (fifo_en_i != en_q);

  // Next pointers/count; clear beats any write or pop in the same cycle
  always_comb begin
    wr_ptr_n = wr_ptr;
    rd_ptr_n = rd_ptr;
    count_n  = count;
    wr_ok    = 1'b0;
    pop_ok   = 1'b0;
    ovf_n    = 1'b0;
    if (!rst_ni || clr) begin
      wr_ptr_n = '0;
      rd_ptr_n = '0;
      count_n  = '0;
    end else begin
      pop_ok = bus.pop & ~empty;
      wr_ok  = bus.wr & (~full | pop_ok);
      ovf_n  = bus.wr & ~wr_ok;
      if (wr_ok)
        wr_ptr_n = wr_ptr + PONE;
      if (pop_ok)
        rd_ptr_n = rd_ptr + PONE;
      unique case ({wr_ok, pop_ok})
        2'b10:   count_n = count + ONE;
        2'b01:   count_n = count - ONE;
        default: count_n = count;
      endcase
    end
  end

  // THRE pending: iir read loses to a set, an accepted write wins over both
  always_comb begin
    set_pend = ((count != '0) && (count_n == '0))
             | (ier_ethrei_i & ~ethrei_q & thre_q);
    pend_n = pend;
    if (iir_rd_i)
      pend_n = 1'b0;
    if (set_pend)
      pend_n = 1'b1;
    if (wr_ok)
      pend_n = 1'b0;
  end

  // Control state register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      thre_q   <= 1'b1;
      pend     <= 1'b0;
      ovf_q    <= 1'b0;
      en_q     <= fifo_en_i;
      ethrei_q <= ier_ethrei_i;
    end else begin
      wr_ptr   <= wr_ptr_n;
      rd_ptr   <= rd_ptr_n;
      count    <= count_n;
      thre_q   <= (count_n == '0);
      pend     <= pend_n;
      ovf_q    <= ovf_n;
      en_q     <= fifo_en_i;
      ethrei_q <= ier_ethrei_i;
    end
  end

  // Data storage, not reset
  always_ff @(posedge clk_i) begin
    if (wr_ok)
      mem[wr_ptr] <= bus.wd;
  end

  assign bus.d      = mem[rd_ptr];
  assign thre_o     = thre_q;
  assign temt_o     = thre_q & sr_empty_i;
  assign thre_irq_o = pend & ier_ethrei_i;
  assign overflow_o = ovf_q;

`ifdef UART16550_TX_LEVEL_EN
  assign level_o = count;
`endif

endmodule

// File: tb/tb_uart16550_tx_fifo_ctrl.sv
// Self-checking bench for uart16550_tx_fifo_ctrl.
// Scoreboard queue holds bytes expected from the transmitter side.
module tb_uart16550_tx_fifo_ctrl;

  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst_n, fifo_en, fifo_rst, sr_empty;
  logic ethrei, iir_rd;
  logic thre, temt, irq, ovf;
`ifdef UART16550_TX_LEVEL_EN
  logic [4:0] level;
`endif

  int checks = 0;
  int errors = 0;
  logic [7:0] q[$];

  uart16550_tx_fifo_ctrl_if bus();

  uart16550_tx_fifo_ctrl #(.DEPTH(DEPTH)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .fifo_en_i    (fifo_en),
    .fifo_rst_i   (fifo_rst),
    .bus          (bus),
    .sr_empty_i   (sr_empty),
    .thre_o       (thre),
    .temt_o       (temt),
    .ier_ethrei_i (ethrei),
    .iir_rd_i     (iir_rd),
    .thre_irq_o   (irq),
    .overflow_o   (ovf)
`ifdef UART16550_TX_LEVEL_EN
    ,
    .level_o      (level)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    fifo_en = 1'b1;
    fifo_rst = 1'b0;
    sr_empty = 1'b1;
    ethrei = 1'b0;
    iir_rd = 1'b0;
    bus.wr = 1'b0;
    bus.wd = 8'h00;
    bus.pop = 1'b0;
    tick;
    tick;
    rst_n = 1'b1;
    tick;
    checks++;
    if (thre !== 1'b1) begin
      errors++; $display("FAIL reset_thre got %b want 1", thre);
    end
    checks++;
    if (temt !== 1'b1) begin
      errors++; $display("FAIL reset_temt got %b want 1", temt);
    end
    checks++;
    if (irq !== 1'b0) begin
      errors++; $display("FAIL reset_irq got %b want 0", irq);
    end
    checks++;
    if (ovf !== 1'b0) begin
      errors++; $display("FAIL reset_ovf got %b want 0", ovf);
    end
    sr_empty = 1'b0;
    #1;
    checks++;
    if (temt !== 1'b0) begin
      errors++; $display("FAIL temt_sr_busy got %b want 0", temt);
    end
    sr_empty = 1'b1;
  endtask

  task automatic test_fifo_fill;
    logic [7:0] exp;
    int n;
    for (int i = 0; i < 17; i++) begin
      bus.wr = 1'b1;
      bus.wd = 8'(i);
      if (i < DEPTH) q.push_back(8'(i));
      tick;
      checks++;
      if (ovf !== (i == 16)) begin
        errors++; $display("FAIL fill_ovf_%0d got %b want %b", i, ovf, (i == 16));
      end
    end
    bus.wr = 1'b0;
    checks++;
    if (thre !== 1'b0) begin
      errors++; $display("FAIL fill_thre got %b want 0", thre);
    end
`ifdef UART16550_TX_LEVEL_EN
    checks++;
    if (level !== 5'd16) begin
      errors++; $display("FAIL fill_level got %0d want 16", level);
    end
`endif
    tick;
    checks++;
    if (ovf !== 1'b0) begin
      errors++; $display("FAIL fill_ovf_width got %b want 0", ovf);
    end
    n = 0;
    for (int k = 0; k < DEPTH + 4 && thre === 1'b0; k++) begin
      exp = (q.size() != 0) ? q.pop_front() : 8'hxx;
      checks++;
      if (bus.d !== exp) begin
        errors++; $display("FAIL fill_pop_%0d got %h want %h", k, bus.d, exp);
      end
      bus.pop = 1'b1;
      tick;
      bus.pop = 1'b0;
      n++;
    end
    checks++;
    if (n != DEPTH || q.size() != 0 || thre !== 1'b1) begin
      errors++;
      $display("FAIL fill_drain got pops=%0d left=%0d thre=%b want 16/0/1",
               n, q.size(), thre);
    end
  endtask

  task automatic test_hold_mode;
    fifo_en = 1'b0;
    tick;
    bus.wr = 1'b1;
    bus.wd = 8'hA5;
    q.push_back(8'hA5);
    tick;
    checks++;
    if (ovf !== 1'b0 || thre !== 1'b0) begin
      errors++; $display("FAIL hold_first got ovf=%b thre=%b want 0/0", ovf, thre);
    end
    bus.wd = 8'h5A;
    tick;
    bus.wr = 1'b0;
    checks++;
    if (ovf !== 1'b1) begin
      errors++; $display("FAIL hold_ovf got %b want 1", ovf);
    end
`ifdef UART16550_TX_LEVEL_EN
    checks++;
    if (level !== 5'd1) begin
      errors++; $display("FAIL hold_level got %0d want 1", level);
    end
`endif
    tick;
    checks++;
    if (ovf !== 1'b0) begin
      errors++; $display("FAIL hold_ovf_width got %b want 0", ovf);
    end
    checks++;
    if (bus.d !== q[0]) begin
      errors++; $display("FAIL hold_data got %h want %h", bus.d, q[0]);
    end
    void'(q.pop_front());
    bus.pop = 1'b1;
    tick;
    checks++;
    if (thre !== 1'b1) begin
      errors++; $display("FAIL hold_thre got %b want 1", thre);
    end
    tick;
    bus.pop = 1'b0;
    checks++;
    if (thre !== 1'b1) begin
      errors++; $display("FAIL pop_empty_thre got %b want 1", thre);
    end
    bus.wr = 1'b1;
    bus.wd = 8'h3C;
    tick;
    bus.wr = 1'b0;
    checks++;
    if (bus.d !== 8'h3C || thre !== 1'b0) begin
      errors++; $display("FAIL hold_after_empty_pop got %h/%b want 3c/0", bus.d, thre);
    end
    bus.pop = 1'b1;
    tick;
    bus.pop = 1'b0;
    fifo_en = 1'b1;
    tick;
  endtask

  task automatic test_thre_irq;
    logic [7:0] vals [3];
    vals[0] = 8'h55;
    vals[1] = 8'h66;
    vals[2] = 8'h77;
    iir_rd = 1'b1;
    tick;
    iir_rd = 1'b0;
    ethrei = 1'b1;
    for (int r = 0; r < 3; r++) begin
      bus.wr = 1'b1;
      bus.wd = vals[r];
      q.push_back(vals[r]);
      tick;
      bus.wr = 1'b0;
      checks++;
      if (irq !== 1'b0) begin
        errors++; $display("FAIL irq_after_wr_%0d got %b want 0", r, irq);
      end
      checks++;
      if (bus.d !== q[0]) begin
        errors++; $display("FAIL irq_data_%0d got %h want %h", r, bus.d, q[0]);
      end
      void'(q.pop_front());
      bus.pop = 1'b1;
      tick;
      bus.pop = 1'b0;
      checks++;
      if (irq !== 1'b1) begin
        errors++; $display("FAIL irq_after_pop_%0d got %b want 1", r, irq);
      end
      if (r == 0) begin
        iir_rd = 1'b1;
        tick;
        iir_rd = 1'b0;
        checks++;
        if (irq !== 1'b0) begin
          errors++; $display("FAIL irq_iir_clear got %b want 0", irq);
        end
      end
    end
    iir_rd = 1'b1;
    tick;
    iir_rd = 1'b0;
    ethrei = 1'b0;
    tick;
    ethrei = 1'b1;
    tick;
    checks++;
    if (irq !== 1'b1) begin
      errors++; $display("FAIL irq_ier_rise got %b want 1", irq);
    end
    ethrei = 1'b0;
    tick;
  endtask

  task automatic test_back_to_back;
    logic [7:0] exp;
    int n;
    for (int i = 0; i < DEPTH; i++) begin
      bus.wr = 1'b1;
      bus.wd = 8'(8'h20 + i);
      q.push_back(8'(8'h20 + i));
      tick;
    end
    bus.wd = 8'hEE;
    bus.pop = 1'b1;
    exp = q.pop_front();
    q.push_back(8'hEE);
    checks++;
    if (bus.d !== exp) begin
      errors++; $display("FAIL b2b_head got %h want %h", bus.d, exp);
    end
    tick;
    bus.wr = 1'b0;
    bus.pop = 1'b0;
    checks++;
    if (ovf !== 1'b0) begin
      errors++; $display("FAIL b2b_ovf got %b want 0", ovf);
    end
`ifdef UART16550_TX_LEVEL_EN
    checks++;
    if (level !== 5'd16) begin
      errors++; $display("FAIL b2b_level got %0d want 16", level);
    end
`endif
    n = 0;
    for (int k = 0; k < DEPTH + 4 && thre === 1'b0; k++) begin
      exp = (q.size() != 0) ? q.pop_front() : 8'hxx;
      checks++;
      if (bus.d !== exp) begin
        errors++; $display("FAIL b2b_pop_%0d got %h want %h", k, bus.d, exp);
      end
      bus.pop = 1'b1;
      tick;
      bus.pop = 1'b0;
      n++;
    end
    checks++;
    if (n != DEPTH || q.size() != 0) begin
      errors++; $display("FAIL b2b_count got %0d left=%0d want 16/0", n, q.size());
    end
  endtask

  task automatic test_clear;
    for (int mode = 0; mode < 2; mode++) begin
      for (int i = 0; i < 8; i++) begin
        bus.wr = 1'b1;
        bus.wd = 8'(8'h40 + i);
        tick;
      end
      bus.wd = 8'h99;
      if (mode == 0) fifo_rst = 1'b1;
      else fifo_en = 1'b0;
      tick;
      bus.wr = 1'b0;
      fifo_rst = 1'b0;
      checks++;
      if (thre !== 1'b1) begin
        errors++; $display("FAIL clear_thre_%0d got %b want 1", mode, thre);
      end
`ifdef UART16550_TX_LEVEL_EN
      checks++;
      if (level !== 5'd0) begin
        errors++; $display("FAIL clear_level_%0d got %0d want 0", mode, level);
      end
`endif
      fifo_en = 1'b1;
      tick;
      bus.wr = 1'b1;
      bus.wd = 8'h11;
      tick;
      bus.wr = 1'b0;
      checks++;
      if (bus.d !== 8'h11) begin
        errors++; $display("FAIL clear_lost_%0d got %h want 11", mode, bus.d);
      end
      bus.pop = 1'b1;
      tick;
      bus.pop = 1'b0;
      checks++;
      if (thre !== 1'b1) begin
        errors++; $display("FAIL clear_single_%0d got %b want 1", mode, thre);
      end
    end
  endtask

  initial begin
    test_reset;
    test_fifo_fill;
    test_hold_mode;
    test_thre_irq;
    test_back_to_back;
    test_clear;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
